exc_commit_ctrl: RTL
====================

Name: exc_commit_ctrl

Overview:
- Exception/ERTN commit sequencer at the WB stage of the 5-stage LoongArch pipeline.
- Each cycle it takes the WB instruction's exception flags, the ERTN flag and the CSR interrupt-pending signal, and picks exactly one architectural event.
- It drives the CSR file's exception/ERTN update ports, flushes the pipeline, and holds a redirect request to IF until IF accepts it.

Parameters:
- PC_W, 32, PC/address width.
- INT_EN, 1, when 0 has_int is ignored (no interrupts taken).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_valid  in  1  valid instruction in WB this cycle
- wb_pc  in  PC_W  PC of WB instruction
- wb_exc_vec  in  5  {adef, ine, sys, brk, ale} flags from earlier stages
- wb_ertn  in  1  WB instruction is ERTN
- has_int  in  1  CSR interrupt pending (ESTAT.IS & ECFG.LIE & CRMD.IE)
- exc_entry  in  PC_W  CSR EENTRY value
- exc_retaddr  in  PC_W  CSR ERA value
- csr_wb_exc  out  1  one-cycle exception commit pulse to CSR
- csr_wb_ecode  out  6  Ecode for CSR
- csr_wb_esubcode  out  9  EsubCode for CSR
- csr_wb_pc  out  PC_W  ERA value for CSR
- csr_ertn_flush  out  1  one-cycle ERTN commit pulse to CSR
- wb_commit  out  1  WB instruction retires normally (regfile/CSR write enable gate)
- pipe_flush  out  1  squash all younger instructions in IF..MEM
- redir_valid  out  1  redirect request to IF
- redir_pc  out  PC_W  redirect target
- redir_ready  in  1  IF accepts redirect
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REDIR. Reset, or rst asserted in any state, forces IDLE next cycle.
- While rst is high, every output is 0: redir_pc = 0, ecode/esubcode/pc = 0.
- Event selection happens only in IDLE with wb_valid=1. In REDIR, WB inputs are ignored.
- Event priority, highest first:
  - INT (has_int & INT_EN): ecode 0x00
  - ADEF: ecode 0x08, esub 0
  - INE: ecode 0x0D
  - SYS: ecode 0x0B
  - BRK: ecode 0x0C
  - ALE: ecode 0x09
  - ERTN
  - none
- esubcode is 0 for all events.
- Multiple flags set: only the highest-priority event is reported. An interrupt or exception on an ERTN instruction suppresses the ERTN.
- Commit cycle T (IDLE, wb_valid, event chosen): all outputs below are combinational in T.
  - Exception: csr_wb_exc=1, csr_wb_ecode/esubcode as above, csr_wb_pc=wb_pc.
  - ERTN: csr_ertn_flush=1.
  - pipe_flush=1; wb_commit=0.
  - Target is registered at the end of T: exc_entry for an exception, exc_retaddr for ERTN. These are the pre-update CSR values.
  - Next state is REDIR.
- csr_wb_exc and csr_ertn_flush are never both 1. Each is high for exactly one cycle per event.
- No event, IDLE, wb_valid=1: wb_commit=1, no other output asserted.
- wb_valid=0 in IDLE: all outputs 0, has_int is not taken. Interrupts attach only to a valid WB instruction, which is not committed.
- REDIR:
  - redir_valid=1 and pipe_flush=1.
  - redir_pc holds the captured target, stable until the handshake.
  - Handshake = redir_valid & redir_ready. On the handshake cycle pipe_flush stays 1 and the next state is IDLE.
  - redir_ready high in the first REDIR cycle means a single-cycle REDIR.
  - Back-to-back: a new event can be taken in the first IDLE cycle after the handshake.
- busy = (state == REDIR).
- wb_commit is 0 in REDIR.
- redir_pc is cleared to 0 on the IDLE return.

Test Plan:
- Reset: rst high 3 cycles with wb_valid=1 and wb_exc_vec=5'b11111 -> all outputs 0, busy=0, no csr pulses.
- Normal retire: IDLE, wb_valid=1, flags 0, has_int=0 -> wb_commit=1 each cycle; csr_wb_exc, pipe_flush, redir_valid stay 0.
- ALE with delayed accept: wb_pc=0x1c000100, vec=5'b00001, exc_entry=0x1c008000, redir_ready low for 3 cycles.
  - T: csr_wb_exc=1, ecode=0x09, csr_wb_pc=0x1c000100, pipe_flush=1.
  - T+1..T+4: redir_valid=1, redir_pc=0x1c008000.
  - redir_ready high at T+4 -> IDLE at T+5.
- Priority: has_int=1, vec=5'b00110 (sys+brk), wb_ertn=1 -> ecode=0x00 and csr_ertn_flush=0. Repeat with has_int=0 -> ecode=0x0B. Repeat with INT_EN=0 and has_int=1 -> ecode=0x0B.
- ERTN: wb_ertn=1, exc_retaddr=0x1c000abc, redir_ready=1 -> csr_ertn_flush pulse for 1 cycle, redir_pc=0x1c000abc next cycle, IDLE after.
- Reset mid-REDIR: rst asserted in the second REDIR cycle -> next cycle IDLE, redir_valid=0, busy=0; no csr pulse during or after reset.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/ERTN commit sequencer: picks one architectural event per
// valid WB instruction, pulses the CSR update ports and holds a redirect until IF accepts it.
module exc_commit_ctrl #(
    parameter int unsigned PC_W   = 32,
    parameter bit          INT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [PC_W-1:0] wb_pc,
    input  logic [4:0]      wb_exc_vec,
    input  logic            wb_ertn,
    input  logic            has_int,
    input  logic [PC_W-1:0] exc_entry,
    input  logic [PC_W-1:0] exc_retaddr,
    output logic            csr_wb_exc,
    output logic [5:0]      csr_wb_ecode,
    output logic [8:0]      csr_wb_esubcode,
    output logic [PC_W-1:0] csr_wb_pc,
    output logic            csr_ertn_flush,
    output logic            wb_commit,
    output logic            pipe_flush,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            busy
);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_redir_pc;
    logic [PC_W-1:0] w_redir_pc_nxt;
    logic            w_int;
    logic            w_exc;
    logic [5:0]      w_ecode;

    // Priority encode: interrupt first, then {adef, ine, sys, brk, ale}.
    always_comb begin
        w_int   = has_int & INT_EN;
        w_exc   = w_int | (|wb_exc_vec);
        w_ecode = ECODE_ALE;
        if (w_int)              w_ecode = ECODE_INT;
        else if (wb_exc_vec[4]) w_ecode = ECODE_ADEF;
        else if (wb_exc_vec[3]) w_ecode = ECODE_INE;
        else if (wb_exc_vec[2]) w_ecode = ECODE_SYS;
        else if (wb_exc_vec[1]) w_ecode = ECODE_BRK;
    end

    always_ff @(posedge clk) begin
        r_state    <= w_state_nxt;
        r_redir_pc <= w_redir_pc_nxt;
    end

    // Next state and all outputs; reset overrides everything to zero.
    always_comb begin
        w_state_nxt     = r_state;
        w_redir_pc_nxt  = r_redir_pc;
        csr_wb_exc      = 1'b0;
        csr_wb_ecode    = '0;
        csr_wb_esubcode = '0;
        csr_wb_pc       = '0;
        csr_ertn_flush  = 1'b0;
        wb_commit       = 1'b0;
        pipe_flush      = 1'b0;
        redir_valid     = 1'b0;
        redir_pc        = '0;
        busy            = 1'b0;
        if (rst) begin
            w_state_nxt    = ST_IDLE;
            w_redir_pc_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wb_valid) begin
                        if (w_exc) begin
                            csr_wb_exc     = 1'b1;
                            csr_wb_ecode   = w_ecode;
                            csr_wb_pc      = wb_pc;
                            pipe_flush     = 1'b1;
                            w_redir_pc_nxt = exc_entry;
                            w_state_nxt    = ST_REDIR;
                        end else if (wb_ertn) begin
                            csr_ertn_flush = 1'b1;
                            pipe_flush     = 1'b1;
                            w_redir_pc_nxt = exc_retaddr;
                            w_state_nxt    = ST_REDIR;
                        end else begin
                            wb_commit = 1'b1;
                        end
                    end
                end
                ST_REDIR: begin
                    redir_valid = 1'b1;
                    redir_pc    = r_redir_pc;
                    pipe_flush  = 1'b1;
                    busy        = 1'b1;
                    if (redir_ready) begin
                        w_state_nxt    = ST_IDLE;
                        w_redir_pc_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_redir_pc_nxt = '0;
                end
            endcase
        end
    end

endmodule
